// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers for the cipher core.
package aes_pkg;

  localparam logic [2:0] KS_128 = 3'b000;
  localparam logic [2:0] KS_192 = 3'b010;
  localparam logic [2:0] KS_256 = 3'b100;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } fsm_t;

  // Unrecognised key-size codes fall back to AES-128.
  function automatic logic [3:0] nr_of(input logic [2:0] ks);
    case (ks)
      KS_192:  nr_of = NR_192;
      KS_256:  nr_of = NR_256;
      default: nr_of = NR_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // col[31:24] is row 0 of the column.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    mix_column = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                  a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                  a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                  xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_cipher_core_if.sv
// Block-level bus between the key-expansion stage, the cipher core and the IO block.
interface aes_cipher_core_if #(
  parameter int unsigned KEXP_W = 1920,
  parameter int unsigned BLK_W  = 128
);
  logic              start;
  logic [2:0]        keySize;
  logic [0:KEXP_W-1] keyExp;
  logic [0:BLK_W-1]  plaintext;
  logic [0:BLK_W-1]  ciphertext;
  logic              busy;
  logic              done;

  modport master (
    output start, keySize, keyExp, plaintext,
    input  ciphertext, busy, done
  );

  modport slave (
    input  start, keySize, keyExp, plaintext,
    output ciphertext, busy, done
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign q = SBOX[{a, 3'b000} +: 8];

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128/192/256 encryption core: one round per clock from a precomputed key schedule.
module aes_cipher_core #(
  parameter int unsigned KEXP_W = 1920,
  parameter int unsigned BLK_W  = 128
) (
  input logic          clk,
  input logic          rst,
  aes_cipher_core_if.slave bus
);
  import aes_pkg::*;

  localparam int unsigned NRK = KEXP_W / BLK_W;

  fsm_t             fsm;
  logic [3:0]       rnd;
  logic [3:0]       nr;
  logic [0:BLK_W-1] st;
  logic [0:BLK_W-1] sb;
  logic [0:BLK_W-1] sr;
  logic [0:BLK_W-1] mc;
  logic [0:BLK_W-1] rk;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a(st[8*g +: 8]),
      .q(sb[8*g +: 8])
    );
  end

  // Byte 4*c+r sits at row r, column c; ShiftRows rotates row r left by r columns.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[32*c +: 32] = mix_column(sr[32*c +: 32]);
    end
  end

  // Counter values beyond the latched Nr cannot occur; they select rk0.
  always_comb begin
    rk = bus.keyExp[0 +: BLK_W];
    for (int unsigned i = 1; i < NRK; i++) begin
      if (rnd == 4'(i) && rnd <= nr) rk = bus.keyExp[BLK_W*i +: BLK_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm            <= IDLE;
      rnd            <= '0;
      nr             <= NR_128;
      st             <= '0;
      bus.ciphertext <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.start) begin
            st       <= bus.plaintext ^ bus.keyExp[0 +: BLK_W];
            nr       <= nr_of(bus.keySize);
            rnd      <= 4'd1;
            bus.busy <= 1'b1;
            fsm      <= (nr_of(bus.keySize) > 4'd2) ? ROUND : FINAL;
          end
        end
        ROUND: begin
          st  <= mc ^ rk;
          rnd <= rnd + 4'd1;
          if (rnd == nr - 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          bus.ciphertext <= sr ^ rk;
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          rnd            <= '0;
          fsm            <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core using FIPS-197 example keys and ciphertexts.
module tb_aes_cipher_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_cipher_core_if #(.KEXP_W(1920), .BLK_W(128)) bus ();

  aes_cipher_core #(.KEXP_W(1920), .BLK_W(128)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:1919] ke_ref;

  logic [0:2047] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:127] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  function automatic logic [31:0] subw(input logic [31:0] w);
    subw = {sbox_tbl[8*int'(w[31:24]) +: 8], sbox_tbl[8*int'(w[23:16]) +: 8],
            sbox_tbl[8*int'(w[15:8]) +: 8],  sbox_tbl[8*int'(w[7:0]) +: 8]};
  endfunction

  // Key schedule for key bytes 00,01,02,... of nk words.
  function automatic logic [0:1919] kexp(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [0:1919] res;
    int nwords;
    nwords = 4 * (nk + 7);
    rc = 8'h01;
    res = '0;
    for (int i = 0; i < nk; i++)
      w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    for (int i = nk; i < nwords; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nwords; i++) res[32*i +: 32] = w[i];
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until done; busy count includes the start-edge cycle. cyc=-1 on timeout.
  task automatic wait_done(input bit disturb, output int cyc, output int bc);
    bc  = bus.busy ? 1 : 0;
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (disturb && k == 3) bus.start = 1'b1;
      if (disturb && k == 4) begin
        bus.start   = 1'b0;
        bus.keySize = 3'b100;
      end
      if (bus.done) begin
        cyc = k;
        break;
      end
      if (bus.busy) bc++;
    end
  endtask

  task automatic run_block(input string tag, input logic [2:0] ks, input int nk,
                           input int nr_exp, input logic [0:127] ct_exp, input bit disturb);
    int cyc, bc;
    bus.keySize   = ks;
    bus.keyExp    = kexp(nk);
    ke_ref        = bus.keyExp;
    bus.plaintext = PT;
    bus.start     = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.plaintext = '0;
    wait_done(disturb, cyc, bc);
    check({tag, "_latency"}, 128'(cyc), 128'(nr_exp));
    check({tag, "_busycycles"}, 128'(bc), 128'(nr_exp));
    check({tag, "_ct"}, bus.ciphertext, ct_exp);
    check({tag, "_busy_at_done"}, 128'(bus.busy), 128'd0);
    step();
    check({tag, "_done_pulse"}, 128'(bus.done), 128'd0);
    check({tag, "_ct_held"}, bus.ciphertext, ct_exp);
    bus.keySize = ks;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.busy) check("keyexp_stable", bus.keyExp[0 +: 128] ^ bus.keyExp[1792 +: 128],
                                ke_ref[0 +: 128] ^ ke_ref[1792 +: 128]);
  end

  initial begin
    int c1, c2, bc;
    bus.start     = 1'b0;
    bus.keySize   = 3'b000;
    bus.keyExp    = '0;
    bus.plaintext = '0;
    ke_ref        = '0;
    #1;
    check("reset_ct", bus.ciphertext, 128'd0);
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_done", 128'(bus.done), 128'd0);
    #20;
    rst = 1'b0;
    step();

    run_block("aes128", 3'b000, 4, 10, CT_128, 1'b0);
    run_block("aes192", 3'b010, 6, 12, CT_192, 1'b0);
    run_block("aes256", 3'b100, 8, 14, CT_256, 1'b0);
    run_block("disturb", 3'b000, 4, 10, CT_128, 1'b1);
    run_block("ks111", 3'b111, 4, 10, CT_128, 1'b0);

    // Back-to-back: start held through the first done cycle.
    run_block("pre_b2b", 3'b010, 6, 12, CT_192, 1'b0);
    bus.keySize   = 3'b000;
    bus.keyExp    = kexp(4);
    ke_ref        = bus.keyExp;
    bus.plaintext = PT;
    bus.start     = 1'b1;
    step();
    wait_done(1'b0, c1, bc);
    check("b2b_first_latency", 128'(c1), 128'd10);
    check("b2b_first_ct", bus.ciphertext, CT_128);
    step();
    bus.start = 1'b0;
    check("b2b_relaunch_busy", 128'(bus.busy), 128'd1);
    bus.plaintext = '0;
    wait_done(1'b0, c2, bc);
    check("b2b_spacing", 128'(c2 + 1), 128'd11);
    check("b2b_second_ct", bus.ciphertext, CT_128);

    // Asynchronous reset mid-block, between clock edges.
    step();
    bus.plaintext = PT;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #2;
    rst = 1'b1;
    #1;
    check("rst_ct", bus.ciphertext, 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    #1;
    rst = 1'b0;
    step();
    check("rst_aborted_busy", 128'(bus.busy), 128'd0);
    for (int k = 0; k < 12; k++) step();
    check("rst_no_partial_ct", bus.ciphertext, 128'd0);
    run_block("post_rst", 3'b000, 4, 10, CT_128, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
- Iterative AES encryption engine that consumes the expanded key schedule from the key-expansion stage and encrypts one 128-bit block. Each clock performs one round.
- Sits directly downstream of key expansion and upstream of the output/IO block.
- Supports AES-128, AES-192 and AES-256, selected by the same keySize code used by key expansion.

Parameters:
- KEXP_W, 1920, expanded-key bus width (15 round keys x 128).
- BLK_W, 128, block width; fixed, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request to encrypt; sampled only in IDLE.
- keySize  input  3  3'b010 = AES-192 (Nr=12); 3'b100 = AES-256 (Nr=14); any other code = AES-128 (Nr=10).
- keyExp  input  [0:1919]  round key r = keyExp[128r : 128r+127]; byte 0 at bits [0:7].
- plaintext  input  [0:127]  input block; byte 0 at [0:7], column-major state order per FIPS-197.
- ciphertext  output  [0:127]  registered result, held until the next completion or reset.
- busy  output  1  high while a block is in flight.
- done  output  1  one-cycle pulse when ciphertext is updated.

Behaviour:
- Reset values: ciphertext=0, busy=0, done=0, FSM=IDLE, round counter=0, state register=0.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - start=1 at edge E0: state <= plaintext ^ rk0; Nr is latched from keySize; round<=1; busy<=1.
  - If Nr-1 > 1 rounds remain, go to ROUND.
- ROUND:
  - Each edge: state <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[round]; round++.
  - When round==Nr-1 completes, go to FINAL.
- FINAL:
  - At one edge: ciphertext <= ShiftRows(SubBytes(state)) ^ rk[Nr]; done<=1; busy<=0; go to IDLE.
- Latency: the result is registered at edge E0+Nr. done is high for exactly the cycle after that edge, i.e. 10/12/14 clocks after start is sampled.
- Throughput: a new start is accepted in the cycle done is high, which gives back-to-back blocks every Nr+1 cycles.
- start while busy is ignored. It is neither queued nor an error.
- keySize is sampled only at the start edge; later changes have no effect on the block in flight.
- keyExp and plaintext are not latched wholesale:
  - plaintext is consumed at the start edge only.
  - keyExp must stay stable from the start edge through the done cycle. The upstream controller guarantees this; the bench checks it with an assertion.
- done is a single-cycle pulse; it never stays high for two consecutive cycles.
- Round-key selection is a 15:1 mux on the round counter (4 bits). Counter values above Nr are unreachable, and the mux defaults to rk0 for them.
- GF(2^8) arithmetic:
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1b : 0).
  - MixColumns uses the 02/03/01/01 matrix.
- Reset mid-operation: asserting rst at any point returns to IDLE immediately, clears ciphertext/busy/done, and aborts the block. There is no partial output.

Decomposition:
- Package aes_pkg holds:
  - KS_128=3'b000, KS_192=3'b010, KS_256=3'b100.
  - NR_128=10, NR_192=12, NR_256=14.
  - The FSM state enum.
  - A function nr_of(keySize) returning Nr.
  - Functions xtime and mix_column.
- One sub-module: aes_sbox, a combinational 8-bit forward S-box LUT instantiated 16 times. ShiftRows and MixColumns stay inline in the core.

Test Plan:
- AES-128:
  - Stimulus: keyExp = FIPS-197 schedule for key 000102..0f; plaintext 00112233445566778899aabbccddeeff; start pulse.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with done exactly 10 cycles after start; busy high for 10 cycles.
- AES-192:
  - Stimulus: keySize=3'b010; key 000102..17 schedule; same plaintext.
  - Required: dda97ca4864cdfe06eaf70a0ec0d7191, done at cycle 12.
- AES-256:
  - Stimulus: keySize=3'b100; key 000102..1f schedule; same plaintext.
  - Required: 8ea2b7ca516745bfeafc49904b496089, done at cycle 14.
- Protocol:
  - Stimulus: start re-pulsed and keySize changed mid-block.
  - Required: result and timing identical to the undisturbed AES-128 run. A second start held high during the done cycle launches the next block immediately; two results arrive 11 cycles apart.
- Reset:
  - Stimulus: rst asserted at round 5, asynchronously between edges.
  - Required: ciphertext=0, busy=0, done=0 immediately. The next start after release produces the correct 69c4e0d8... result.
- Invalid keySize:
  - Stimulus: keySize=3'b111.
  - Required: behaves as AES-128 (10 rounds, 69c4e0d8...).
